mult_dot_accum: RTL and testbench

- Downstream consumer of the ping-pong 15x15 multiplier stage.
- Accepts one 30-bit product per cycle and sums a programmable number of consecutive products into one dot-product result.
- Queues completed results in a small output FIFO that the next stage drains with a valid/ready handshake.
- Provides backpressure to the product source only when a finished result cannot be queued.

---
 rtl/mult_dot_accum.sv | 169 ++++++++++++++++
 tb/tb_mult_dot_accum.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mult_dot_accum.sv
// mult_dot_accum
// Sums a programmable number of consecutive unsigned products into one
// dot-product result. Completed results are queued in a small FIFO that
// the next stage drains with a valid/ready handshake. The product source
// is stalled only while a finished result cannot be queued.
//
// Ports:
//   clk, rst_n        rising-edge clock, async active-low reset
//   i_prod_valid      i_prod_data holds a product this cycle
//   i_prod_data       unsigned product (PROD_W)
//   o_prod_ready      block accepts a product this cycle
//   i_vec_len         products per vector, 0 means 2^LEN_W (first beat only)
//   o_res_valid       FIFO head valid
//   o_res_data        FIFO head, 0 when empty (ACC_W)
//   i_res_ready       downstream takes the head
//   o_fifo_count      entries currently queued
//   o_busy            vector in progress or result held
module mult_dot_accum #(
  parameter int PROD_W     = 30,
  parameter int LEN_W      = 8,
  parameter int ACC_W      = 38,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_prod_valid,
  input  logic [PROD_W-1:0]             i_prod_data,
  output logic                          o_prod_ready,
  input  logic [LEN_W-1:0]              i_vec_len,
  output logic                          o_res_valid,
  output logic [ACC_W-1:0]              o_res_data,
  input  logic                          i_res_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_busy
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = LEN_W + 1;  // must hold 2^LEN_W
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                 r_state, w_state_nxt;
  logic [ACC_W-1:0]       r_acc,   w_acc_nxt;
  logic [CNT_W-1:0]       r_cnt,   w_cnt_nxt;
  logic [CNT_W-1:0]       r_len,   w_len_nxt;
  logic [ACC_W-1:0]       r_hold,  w_hold_nxt;

  logic [ACC_W-1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [AW:0]            r_count;

  logic                   w_beat, w_pop, w_push, w_can_push;
  logic [ACC_W-1:0]       w_push_data, w_prod_ext, w_sum;
  logic [CNT_W-1:0]       w_len_in, w_cnt_inc;

  assign o_prod_ready = (r_state != HOLD);
  assign o_busy       = (r_state != IDLE);
  assign o_res_valid  = (r_count != '0);
  assign o_res_data   = o_res_valid ? r_mem[r_rptr] : '0;
  assign o_fifo_count = r_count;

  assign w_beat     = i_prod_valid && o_prod_ready;
  assign w_pop      = o_res_valid && i_res_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_can_push = (r_count < DEPTH_C) || w_pop;
  assign w_prod_ext = ACC_W'(i_prod_data);
  assign w_sum      = r_acc + w_prod_ext;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_len_in   = (i_vec_len == '0) ? {1'b1, {LEN_W{1'b0}}}
                                        : {1'b0, i_vec_len};

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_hold_nxt  = r_hold;
    w_push      = 1'b0;
    w_push_data = '0;
    unique case (r_state)
      IDLE: begin
        if (w_beat) begin
          w_len_nxt = w_len_in;
          if (w_len_in == CNT_W'(1)) begin
            // Single-product vector completes on its first beat.
            w_acc_nxt = '0;
            w_cnt_nxt = '0;
            if (w_can_push) begin
              w_push      = 1'b1;
              w_push_data = w_prod_ext;
            end else begin
              w_hold_nxt  = w_prod_ext;
              w_state_nxt = HOLD;
            end
          end else begin
            w_acc_nxt   = w_prod_ext;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (w_beat) begin
          if (w_cnt_inc == r_len) begin
            w_acc_nxt = '0;
            w_cnt_nxt = '0;
            if (w_can_push) begin
              w_push      = 1'b1;
              w_push_data = w_sum;
              w_state_nxt = IDLE;
            end else begin
              w_hold_nxt  = w_sum;
              w_state_nxt = HOLD;
            end
          end else begin
            w_acc_nxt = w_sum;
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      HOLD: begin
        if (w_can_push) begin
          w_push      = 1'b1;
          w_push_data = r_hold;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_push_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_dot_accum.sv
// Self-checking bench for mult_dot_accum: table-driven vectors plus
// hand-written sequences for reset, max length, backpressure, full-FIFO
// push/pop and gapped input. Expected results go to a scoreboard queue
// when a vector's last beat is accepted and are compared on each pop.
module tb_mult_dot_accum;
  localparam int PROD_W = 30, LEN_W = 8, ACC_W = 38, FIFO_DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                i_prod_valid = 1'b0;
  logic [PROD_W-1:0]   i_prod_data = '0;
  logic                o_prod_ready;
  logic [LEN_W-1:0]    i_vec_len = '0;
  logic                o_res_valid;
  logic [ACC_W-1:0]    o_res_data;
  logic                i_res_ready = 1'b1;
  logic [2:0]          o_fifo_count;
  logic                o_busy;

  always #5 clk = ~clk;

  mult_dot_accum #(.PROD_W(PROD_W), .LEN_W(LEN_W), .ACC_W(ACC_W),
                   .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_prod_valid(i_prod_valid), .i_prod_data(i_prod_data),
    .o_prod_ready(o_prod_ready), .i_vec_len(i_vec_len),
    .o_res_valid(o_res_valid), .o_res_data(o_res_data),
    .i_res_ready(i_res_ready), .o_fifo_count(o_fifo_count),
    .o_busy(o_busy));

  logic [ACC_W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [LEN_W-1:0]  vl;
    int                n;
    logic [PROD_W-1:0] base;
    logic [ACC_W-1:0]  exp;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake pop is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && o_res_valid && i_res_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got %0d expected none", o_res_data);
      end else begin
        chk("res_data", 64'(o_res_data), 64'(exp_q.pop_front()));
      end
    end
  end

  // One beat: hold valid until accepted; push expectation on the last beat.
  task automatic beat(input logic [PROD_W-1:0] d, input logic [LEN_W-1:0] vl,
                      input bit last, input logic [ACC_W-1:0] exp);
    int n = 0;
    i_prod_valid = 1'b1; i_prod_data = d; i_vec_len = vl;
    @(negedge clk);
    while (!o_prod_ready && n < 200) begin n++; @(negedge clk); end
    if (!o_prod_ready) begin
      checks++; errors++;
      $display("FAIL beat_timeout: got prod_ready=0 expected 1 within 200 cycles");
    end else if (last) exp_q.push_back(exp);
    @(posedge clk); #1;
    i_prod_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    i_res_ready = 1'b1;
    while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    chk("drain_queue_left", 64'(exp_q.size()), 64'd0);
    chk("drain_fifo_count", 64'(o_fifo_count), 64'd0);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_res_valid"}, 64'(o_res_valid), 64'd0);
    chk({name, "_res_data"}, 64'(o_res_data), 64'd0);
    chk({name, "_fifo_count"}, 64'(o_fifo_count), 64'd0);
    chk({name, "_busy"}, 64'(o_busy), 64'd0);
    chk({name, "_prod_ready"}, 64'(o_prod_ready), 64'd1);
  endtask

  initial begin
    tbl[0] = '{vl: 8'd1, n: 1, base: 30'd7,          exp: 38'd7};
    tbl[1] = '{vl: 8'd1, n: 1, base: 30'd100,        exp: 38'd100};
    tbl[2] = '{vl: 8'd1, n: 1, base: 30'h3FFF_FFFF,  exp: 38'd1073741823};
    tbl[3] = '{vl: 8'd4, n: 4, base: 30'd1,          exp: 38'd10};
    tbl[4] = '{vl: 8'd3, n: 3, base: 30'd5,          exp: 38'd18};
    tbl[5] = '{vl: 8'd8, n: 8, base: 30'd1000,       exp: 38'd8028};

    // Reset state
    #12;
    chk_idle("reset");
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-vector discards the partial sum
    beat(30'd50, 8'd4, 1'b0, '0);
    beat(30'd60, 8'd4, 1'b0, '0);
    chk("midvec_busy", 64'(o_busy), 64'd1);
    rst_n = 1'b0; #3;
    chk_idle("midvec_reset");
    @(posedge clk); #1; rst_n = 1'b1;
    for (int j = 0; j < 4; j++) beat(30'(j + 1), 8'd4, j == 3, 38'd10);
    chk("after_reset_latency_valid", 64'(o_res_valid), 64'd1);
    chk("after_reset_value", 64'(o_res_data), 64'd10);
    drain();

    // Table-driven vectors, back-to-back
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < tbl[i].n; j++)
        beat(tbl[i].base + 30'(j), tbl[i].vl, j == tbl[i].n - 1, tbl[i].exp);
    drain();

    // Single-beat vectors: result visible one cycle after each beat
    beat(30'd7, 8'd1, 1'b1, 38'd7);
    chk("single_lat_7", 64'(o_res_data), 64'd7);
    beat(30'd100, 8'd1, 1'b1, 38'd100);
    chk("single_lat_100", 64'(o_res_data), 64'd100);
    beat(30'h3FFF_FFFF, 8'd1, 1'b1, 38'd1073741823);
    chk("single_lat_max", 64'(o_res_data), 64'd1073741823);
    drain();

    // Max length, max value
    i_res_ready = 1'b0;
    for (int j = 0; j < 256; j++)
      beat(30'h3FFF_FFFF, 8'd0, j == 255, 38'd274877906688);
    chk("maxlen_count", 64'(o_fifo_count), 64'd1);
    chk("maxlen_value", 64'(o_res_data), 64'd274877906688);
    chk("maxlen_busy", 64'(o_busy), 64'd0);
    drain();

    // Backpressure: FIFO fills, fifth result held, sixth beat stalled
    i_res_ready = 1'b0;
    for (int j = 1; j <= 5; j++) beat(30'(j), 8'd1, 1'b1, 38'(j));
    chk("bp_prod_ready", 64'(o_prod_ready), 64'd0);
    chk("bp_count", 64'(o_fifo_count), 64'd4);
    chk("bp_busy", 64'(o_busy), 64'd1);
    chk("bp_head", 64'(o_res_data), 64'd1);
    fork
      beat(30'd6, 8'd1, 1'b1, 38'd6);
      begin
        repeat (3) @(negedge clk);
        chk("bp_still_stalled", 64'(o_prod_ready), 64'd0);
        @(posedge clk); #1;
        i_res_ready = 1'b1;
      end
    join
    drain();

    // Full FIFO with simultaneous push and pop
    i_res_ready = 1'b0;
    for (int j = 0; j < 4; j++) beat(30'(11 + j), 8'd1, 1'b1, 38'(11 + j));
    chk("full_count", 64'(o_fifo_count), 64'd4);
    beat(30'd20, 8'd2, 1'b0, '0);
    i_res_ready = 1'b1;
    beat(30'd22, 8'd2, 1'b1, 38'd42);
    chk("pushpop_count", 64'(o_fifo_count), 64'd4);
    chk("pushpop_busy", 64'(o_busy), 64'd0);
    chk("pushpop_prod_ready", 64'(o_prod_ready), 64'd1);
    drain();

    // Gapped input, vec_len changes mid-vector are ignored
    beat(30'd5, 8'd3, 1'b0, '0);
    repeat (2) @(posedge clk); #1;
    beat(30'd6, 8'd9, 1'b0, '0);
    repeat (2) @(posedge clk); #1;
    chk("gap_busy", 64'(o_busy), 64'd1);
    beat(30'd7, 8'd9, 1'b1, 38'd18);
    chk("gap_result", 64'(o_res_data), 64'd18);
    for (int j = 0; j < 9; j++) beat(30'd1, (j == 0) ? 8'd9 : 8'd2, j == 8, 38'd9);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
